// File: rtl/aes_arb_pkg.sv
// -----------------------------------------------------------------------------
// aes_arb_pkg
//   Shared definitions for the aes256 job arbiter: sequencer state encoding
//   and the key/text data widths used by the arbiter and its testbench.
// -----------------------------------------------------------------------------
package aes_arb_pkg;

  localparam int KEY_W = 256;
  localparam int TXT_W = 128;

  // Job sequencer states.
  typedef enum logic [2:0] {
    BOS    = 3'd0,  // idle, arbitrating
    BASLAT = 3'd1,  // job captured, waiting for core ready to issue start
    BEKLE  = 3'd2,  // job issued, waiting for core result (watchdog running)
    YANIT  = 3'd3,  // response presented to consumer
    BOSALT = 3'd4   // after a timeout: swallow the late core result
  } state_e;

endpackage

// File: rtl/aes_arbiter_rr_secici.sv
// -----------------------------------------------------------------------------
// rr_secici
//   Combinational round-robin picker. Searches the request vector starting
//   at the position after i_ptr (wrapping modulo NUM_REQ) and returns the
//   first active requester.
// Ports
//   i_req    requester valid vector
//   i_ptr    id of the last served requester
//   o_grant  one-hot grant (zero when no request)
//   o_id     binary id of the granted requester
//   o_any    at least one request is active
// -----------------------------------------------------------------------------
module rr_secici #(
  parameter  int NUM_REQ = 2,
  localparam int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDW-1:0]     i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDW-1:0]     o_id,
  output logic               o_any
);

  logic [IDW-1:0] w_idx;

  // NOTE: every signal assigned in an always_comb gets a default at the top;
  // a path that skips an assignment would otherwise infer a latch.
  always_comb begin
    o_grant = '0;
    o_id    = '0;
    o_any   = 1'b0;
    w_idx   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      w_idx = IDW'((int'(i_ptr) + i) % NUM_REQ);
      if (!o_any && i_req[w_idx]) begin
        o_any          = 1'b1;
        o_grant[w_idx] = 1'b1;
        o_id           = w_idx;
      end
    end
  end

endmodule

// File: rtl/aes_arbiter.sv
// -----------------------------------------------------------------------------
// aes_arbiter
//   Shares one aes256 core between NUM_REQ requesters. A round-robin picker
//   selects one job (key, text, mode) per grant; the job is buffered, issued
//   to the core with a single-cycle start pulse, and the core result is
//   returned tagged with the requester id. A watchdog bounds each job; after
//   a timeout the late core result is drained before the next job is issued.
// Ports
//   clk_i, rst_ni          clock (rising edge), async active-low reset
//   req_gecerli_i/hazir_o  per-requester valid / accept
//   req_anahtar_i          keys, requester k at [256k +: 256]
//   req_metin_i            texts, requester k at [128k +: 128]
//   req_mod_i              per-requester mode (0 encrypt, 1 decrypt)
//   rsp_*                  response channel (valid held until rsp_hazir_i)
//   aes_*_o                job to the core, start pulse aes_gecerli_o
//   aes_hazir_i            core ready
//   aes_metin_i/gecerli_i  core result and its one-cycle valid
// -----------------------------------------------------------------------------
module aes_arbiter
  import aes_arb_pkg::*;
#(
  parameter  int NUM_REQ     = 2,
  parameter  int TIMEOUT_CYC = 1024,
  localparam int IDW         = $clog2(NUM_REQ)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NUM_REQ-1:0]       req_gecerli_i,
  output logic [NUM_REQ-1:0]       req_hazir_o,
  input  logic [KEY_W*NUM_REQ-1:0] req_anahtar_i,
  input  logic [TXT_W*NUM_REQ-1:0] req_metin_i,
  input  logic [NUM_REQ-1:0]       req_mod_i,
  output logic                     rsp_gecerli_o,
  input  logic                     rsp_hazir_i,
  output logic [IDW-1:0]           rsp_id_o,
  output logic [TXT_W-1:0]         rsp_metin_o,
  output logic                     rsp_hata_o,
  output logic [KEY_W-1:0]         aes_anahtar_o,
  output logic [TXT_W-1:0]         aes_metin_o,
  output logic                     aes_mod_o,
  output logic                     aes_gecerli_o,
  input  logic                     aes_hazir_i,
  input  logic [TXT_W-1:0]         aes_metin_i,
  input  logic                     aes_gecerli_i
);

  localparam int             WDW     = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYC - 1);

  state_e             r_state, w_next_state;
  logic [IDW-1:0]     r_ptr;
  logic [IDW-1:0]     r_id;
  logic [KEY_W-1:0]   r_key;
  logic [TXT_W-1:0]   r_txt;
  logic               r_mod;
  logic [TXT_W-1:0]   r_rsp_metin;
  logic               r_rsp_hata;
  logic               r_aes_gecerli;
  logic [WDW-1:0]     r_wdog;

  logic [NUM_REQ-1:0] w_grant;
  logic [IDW-1:0]     w_id;
  logic               w_any;
  logic               w_accept;
  logic               w_start;
  logic               w_done_ok;
  logic               w_done_to;
  logic               w_rsp_take;
  logic               w_wd_clr;
  logic               w_wd_inc;
  logic               w_wd_expired;

  rr_secici #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_secici (
    .i_req   (req_gecerli_i),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_id    (w_id),
    .o_any   (w_any)
  );

  assign w_wd_expired = (r_wdog >= WD_LAST);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= BOS;
    else         r_state <= w_next_state;
  end

  // ---------------------------------------------------------------------------
  // Next state and per-cycle control strobes
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_start      = 1'b0;
    w_done_ok    = 1'b0;
    w_done_to    = 1'b0;
    w_rsp_take   = 1'b0;
    w_wd_clr     = 1'b0;
    w_wd_inc     = 1'b0;
    unique case (r_state)
      BOS: begin
        // The winner sees hazir combinationally, so any active request transfers.
        if (w_any) begin
          w_accept     = 1'b1;
          w_next_state = BASLAT;
        end
      end
      BASLAT: begin
        if (aes_hazir_i) begin
          w_start      = 1'b1;
          w_wd_clr     = 1'b1;
          w_next_state = BEKLE;
        end
      end
      BEKLE: begin
        // A result arriving in the expiry cycle still counts as success.
        if (aes_gecerli_i) begin
          w_done_ok    = 1'b1;
          w_next_state = YANIT;
        end else if (w_wd_expired) begin
          w_done_to    = 1'b1;
          w_next_state = YANIT;
        end else begin
          w_wd_inc     = 1'b1;
        end
      end
      YANIT: begin
        if (rsp_hazir_i) begin
          w_rsp_take   = 1'b1;
          w_wd_clr     = 1'b1;
          w_next_state = r_rsp_hata ? BOSALT : BOS;
        end
      end
      BOSALT: begin
        // The timed-out core may still deliver; drop that pulse, or give up
        // after a second watchdog period if it never comes.
        if (aes_gecerli_i || w_wd_expired) w_next_state = BOS;
        else                               w_wd_inc     = 1'b1;
      end
      default: w_next_state = BOS;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Job buffers, response registers, start pulse, watchdog
  // ---------------------------------------------------------------------------
  // NOTE: the job buffers are reset as well because they drive the core
  // interface directly and must read as zero while rst_ni is low.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ptr         <= IDW'(NUM_REQ - 1);
      r_id          <= '0;
      r_key         <= '0;
      r_txt         <= '0;
      r_mod         <= 1'b0;
      r_rsp_metin   <= '0;
      r_rsp_hata    <= 1'b0;
      r_aes_gecerli <= 1'b0;
      r_wdog        <= '0;
    end else begin
      r_aes_gecerli <= w_start;

      if (w_accept) begin
        r_id  <= w_id;
        r_key <= req_anahtar_i[KEY_W*int'(w_id) +: KEY_W];
        r_txt <= req_metin_i[TXT_W*int'(w_id) +: TXT_W];
        r_mod <= req_mod_i[w_id];
      end

      if (w_done_ok) begin
        r_rsp_metin <= aes_metin_i;
        r_rsp_hata  <= 1'b0;
      end else if (w_done_to) begin
        r_rsp_metin <= '0;
        r_rsp_hata  <= 1'b1;
      end

      // Next search starts after the requester just served.
      if (w_rsp_take) r_ptr <= r_id;

      // Saturating so the counter can never wrap back below the limit.
      if (w_wd_clr)                    r_wdog <= '0;
      else if (w_wd_inc && ~&r_wdog)   r_wdog <= r_wdog + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign req_hazir_o   = (rst_ni && (r_state == BOS)) ? w_grant : '0;
  assign rsp_gecerli_o = (r_state == YANIT);
  assign rsp_id_o      = r_id;
  assign rsp_metin_o   = r_rsp_metin;
  assign rsp_hata_o    = r_rsp_hata;
  assign aes_anahtar_o = r_key;
  assign aes_metin_o   = r_txt;
  assign aes_mod_o     = r_mod;
  assign aes_gecerli_o = r_aes_gecerli;

endmodule
